// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: PC command codes, FSM states, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int ADDR_W_DFLT  = 64;
    localparam int INSTR_W_DFLT = 32;

    // Command codes understood by the program counter.
    localparam logic [1:0] PS_STALL  = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_LOAD   = 2'b10;
    localparam logic [1:0] PS_OFFSET = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        HALTED,
        ERROR
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive REQ cycles without an acknowledge and flags the last permitted one.
// Latency: expired is combinational from the count; the count updates on posedge clk.
// Backpressure: none; clear dominates enable.
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise step once per enabled cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // This enabled cycle is the TIMEOUT-th one without an acknowledge.
    assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Drives the program counter, fetches from IMEM at PC_OUT (req/ack) and hands words downstream (valid/ready); optional stall counter under FETCH_SEQ_PERF_EN.
// Latency: one fetch per 2 cycles with zero-latency memory; PS/PC_IN are combinational, INSTR registered on ACK.
// Backpressure: holds INSTR and stalls the PC (PS=00) until INSTR_READY; no new request is issued meanwhile.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int INSTR_W = INSTR_W_DFLT,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  PC_OUT,
    output logic [1:0]         PS,
    output logic [ADDR_W-1:0]  PC_IN,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic               IMEM_ACK,
    input  logic [INSTR_W-1:0] IMEM_DATA,
    output logic               INSTR_VALID,
    output logic [INSTR_W-1:0] INSTR,
    output logic [ADDR_W-1:0]  INSTR_PC,
    input  logic               INSTR_READY,
    input  logic               BR_REQ,
    input  logic               BR_MODE,
    input  logic [ADDR_W-1:0]  BR_TARGET,
    input  logic               HALT,
    output logic               FETCH_ERR,
    output logic [31:0]        STALL_CYCLES
);

    fetch_state_e         state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
    logic [1:0]           ps_cmd;
    logic [1:0]           br_ps;
    logic [ADDR_W-1:0]    pc_in_dat;
    logic                 tmo_en;
    logic                 tmo_clr;
    logic                 tmo_expired;

    assign br_ps = BR_MODE ? PS_OFFSET : PS_LOAD;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clr),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    // Next state, PC command and instruction capture; branch beats ack/accept beats timeout beats halt.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        ps_cmd     = PS_STALL;
        pc_in_dat  = '0;
        tmo_en     = 1'b0;
        tmo_clr    = 1'b1;
        case (state_q)
            IDLE, HALTED: begin
                if (BR_REQ) begin
                    ps_cmd    = br_ps;
                    pc_in_dat = BR_TARGET;
                end
                state_d = HALT ? HALTED : REQ;
            end
            REQ: begin
                if (BR_REQ) begin
                    ps_cmd    = br_ps;
                    pc_in_dat = BR_TARGET;
                    state_d   = HALT ? HALTED : REQ;
                end else if (IMEM_ACK) begin
                    instr_d    = IMEM_DATA;
                    instr_pc_d = PC_OUT;
                    state_d    = HOLD;
                end else begin
                    tmo_en  = 1'b1;
                    tmo_clr = 1'b0;
                    if (tmo_expired) begin
                        state_d = ERROR;
                    end
                end
            end
            HOLD: begin
                if (BR_REQ) begin
                    ps_cmd    = br_ps;
                    pc_in_dat = BR_TARGET;
                    state_d   = HALT ? HALTED : REQ;
                end else if (INSTR_READY) begin
                    ps_cmd  = PS_INC;
                    state_d = HALT ? HALTED : REQ;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign PS          = ps_cmd;
    assign PC_IN       = pc_in_dat;
    assign IMEM_REQ    = (state_q == REQ);
    assign IMEM_ADDR   = (state_q == REQ) ? PC_OUT : '0;
    assign INSTR_VALID = (state_q == HOLD);
    assign INSTR       = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign FETCH_ERR   = (state_q == ERROR);

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of fetch cycles where the PC is held.
    always_comb begin
        stall_d = stall_q;
        if (((state_q == REQ) || (state_q == HOLD)) && (ps_cmd == PS_STALL) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign STALL_CYCLES = stall_q;
`else
    assign STALL_CYCLES = '0;
`endif

endmodule
